// File: rtl/pipeline_hazard_controller.sv
// rtl/pipeline_hazard_controller.sv - stall/flush sequencer for the 5-stage pipeline registers
module pipeline_hazard_controller #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MEM_TIMEOUT    = 255,
    parameter int COUNT_WIDTH    = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [REG_ADDR_WIDTH-1:0] idRs1Addr,
    input  logic [REG_ADDR_WIDTH-1:0] idRs2Addr,
    input  logic                      idUsesRs1,
    input  logic                      idUsesRs2,
    input  logic [REG_ADDR_WIDTH-1:0] exRdAddr,
    input  logic                      exMemoryReadEnable,
    input  logic                      memBranchTaken,
    input  logic                      memAccessValid,
    input  logic                      dataMemoryReady,
    output logic                      pcStall,
    output logic                      ifIdStall,
    output logic                      ifIdFlush,
    output logic                      idExStall,
    output logic                      idExFlush,
    output logic                      exMemStall,
    output logic                      exMemFlush,
    output logic                      memWbBubble,
    output logic [COUNT_WIDTH-1:0]    stallCount,
    output logic                      memError
);
    localparam int WAIT_WIDTH = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_WIDTH-1:0] TIMEOUT_VALUE = WAIT_WIDTH'(MEM_TIMEOUT);

    typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

    state_t                state;
    state_t                next_state;
    logic [WAIT_WIDTH-1:0] wait_count;
    logic [WAIT_WIDTH-1:0] wait_count_next;
    logic                  mem_error_next;
    logic                  load_use;
    logic                  mem_wait;

    assign load_use = exMemoryReadEnable && (exRdAddr != '0) &&
                      ((idUsesRs1 && (idRs1Addr == exRdAddr)) ||
                       (idUsesRs2 && (idRs2Addr == exRdAddr)));
    assign mem_wait = memAccessValid && !dataMemoryReady;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= RUN;
            wait_count <= '0;
            memError   <= 1'b0;
            stallCount <= '0;
        end else begin
            state      <= next_state;
            wait_count <= wait_count_next;
            memError   <= mem_error_next;
            if (pcStall && (stallCount != {COUNT_WIDTH{1'b1}}))
                stallCount <= stallCount + COUNT_WIDTH'(1);
        end
    end

    // wait_count is always 0 in RUN, so the timeout compare can only fire from MEM_WAIT
    always_comb begin
        next_state      = state;
        wait_count_next = wait_count;
        mem_error_next  = memError;
        case (state)
            HALT: begin
                next_state = HALT;
            end
            default: begin
                if (mem_wait) begin
                    if (wait_count == TIMEOUT_VALUE) begin
                        next_state     = HALT;
                        mem_error_next = 1'b1;
                    end else if (state == RUN) begin
                        next_state      = MEM_WAIT;
                        wait_count_next = WAIT_WIDTH'(1);
                    end else begin
                        next_state      = MEM_WAIT;
                        wait_count_next = wait_count + WAIT_WIDTH'(1);
                    end
                end else begin
                    next_state      = RUN;
                    wait_count_next = '0;
                end
            end
        endcase
    end

    always_comb begin
        pcStall     = 1'b0;
        ifIdStall   = 1'b0;
        ifIdFlush   = 1'b0;
        idExStall   = 1'b0;
        idExFlush   = 1'b0;
        exMemStall  = 1'b0;
        exMemFlush  = 1'b0;
        memWbBubble = 1'b0;
        if (!reset) begin
            if ((state == HALT) || mem_wait) begin
                pcStall     = 1'b1;
                ifIdStall   = 1'b1;
                idExStall   = 1'b1;
                exMemStall  = 1'b1;
                memWbBubble = 1'b1;
            end else if (memBranchTaken) begin
                ifIdFlush  = 1'b1;
                idExFlush  = 1'b1;
                exMemFlush = 1'b1;
            end else if (load_use) begin
                pcStall   = 1'b1;
                ifIdStall = 1'b1;
                idExFlush = 1'b1;
            end
        end
    end
endmodule
